// File: rtl/serial_bus_pkg.sv
// Shared types and helpers for the serial master/slave bus port.
package serial_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CTRL,
    WRITE,
    WAIT_RD,
    READ,
    DONE
  } state_e;

  localparam logic RW_WRITE  = 1'b1;
  localparam logic RW_READ   = 1'b0;
  localparam logic START_BIT = 1'b1;

  // Control frame: start bit, slave id, rw bit.
  function automatic int unsigned ctrl_len(input int unsigned id_width);
    return id_width + 2;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_bus_shifter.sv
// Loadable MSB-first shift register with a bits-remaining counter.
// next_data_c exposes the register's next value so callers can register serial outputs in step.
module serial_bus_shifter #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             shift_en,
  input  logic             shift_in,
  output logic [WIDTH-1:0] next_data_c,
  output logic [CNT_W-1:0] cnt_q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data;
      cnt_d  = load_cnt;
    end else if (shift_en) begin
      data_d = {data_q[WIDTH-2:0], shift_in};
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  assign next_data_c = data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_bus_master_port.sv
// Master-side serial bus port: parallel command -> control/wD/valid frames; collects rD on reads.
// Build option SERIAL_BUS_PARITY_EN appends an even-parity bit to write and read data words.
module serial_bus_master_port
  import serial_bus_pkg::*;
#(
  parameter int unsigned SLAVES     = 4,
  parameter int unsigned ID_WIDTH   = $clog2(SLAVES),
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic                  cmd_rw,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  control,
  output logic                  wD,
  output logic                  valid,
  input  logic                  rD,
  input  logic                  ready
);

`ifdef SERIAL_BUS_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif
  localparam int unsigned CTRL_LEN = ctrl_len(ID_WIDTH);
  localparam int unsigned WORD_LEN = DATA_WIDTH + PAR_BITS;
  localparam int unsigned SH_W     = max_u(CTRL_LEN, DATA_WIDTH + 1);
  localparam int unsigned CNT_W    = $clog2(SH_W + 1);
  localparam int unsigned TCNT_W   = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic                  rw_q, rw_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  control_q, control_d;
  logic                  wd_q, wd_d;
  logic                  valid_q, valid_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  sh_load;
  logic [SH_W-1:0]       sh_load_data;
  logic [CNT_W-1:0]      sh_load_cnt;
  logic                  sh_shift;
  logic                  sh_shift_in;
  logic [SH_W-1:0]       sh_next;
  logic [CNT_W-1:0]      sh_cnt;

  logic [SH_W-1:0]       ctrl_word;
  logic [SH_W-1:0]       wr_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_err;

  // One shifter is time-shared by the control frame, write word and read capture.
  serial_bus_shifter #(
    .WIDTH (SH_W),
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk         (clk),
    .rst_n       (rstN),
    .load        (sh_load),
    .load_data   (sh_load_data),
    .load_cnt    (sh_load_cnt),
    .shift_en    (sh_shift),
    .shift_in    (sh_shift_in),
    .next_data_c (sh_next),
    .cnt_q       (sh_cnt)
  );

  // Left-aligned words so the first bit to send sits at the shifter MSB.
  always_comb begin
    ctrl_word = SH_W'({START_BIT, cmd_id, cmd_rw}) << (SH_W - CTRL_LEN);
`ifdef SERIAL_BUS_PARITY_EN
    wr_word   = SH_W'({wdata_q, ^wdata_q}) << (SH_W - WORD_LEN);
    rd_word   = sh_next[DATA_WIDTH:1];
    rd_err    = (^rd_word) != sh_next[0];
`else
    wr_word   = SH_W'(wdata_q) << (SH_W - WORD_LEN);
    rd_word   = sh_next[DATA_WIDTH-1:0];
    rd_err    = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    rw_d         = rw_q;
    wdata_d      = wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    sh_load      = 1'b0;
    sh_load_data = '0;
    sh_load_cnt  = '0;
    sh_shift     = 1'b0;
    sh_shift_in  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rw_d         = cmd_rw;
          wdata_d      = cmd_wdata;
          sh_load      = 1'b1;
          sh_load_data = ctrl_word;
          sh_load_cnt  = CNT_W'(CTRL_LEN);
          state_d      = CTRL;
        end
      end
      CTRL: begin
        if (sh_cnt > CNT_W'(1)) begin
          sh_shift = 1'b1;
        end else begin
          unique case (rw_q)
            RW_WRITE: begin
              sh_load      = 1'b1;
              sh_load_data = wr_word;
              sh_load_cnt  = CNT_W'(WORD_LEN);
              state_d      = WRITE;
            end
            RW_READ: begin
              sh_load      = 1'b1;
              sh_load_data = '0;
              sh_load_cnt  = CNT_W'(WORD_LEN);
              tcnt_d       = '0;
              state_d      = WAIT_RD;
            end
          endcase
        end
      end
      WRITE: begin
        if (sh_cnt > CNT_W'(1)) begin
          sh_shift = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = DONE;
        end
      end
      WAIT_RD: begin
        // A low ready wins even on the final timeout cycle.
        if (!ready) begin
          state_d = READ;
        end else if (tcnt_q >= TCNT_W'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = DONE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      READ: begin
        sh_shift    = 1'b1;
        sh_shift_in = rD;
        if (sh_cnt <= CNT_W'(1)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rd_word;
          rsp_err_d   = rd_err;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Serial outputs follow the state being entered so they line up with it.
    control_d   = (state_d == CTRL)  ? sh_next[SH_W-1] : 1'b0;
    wd_d        = (state_d == WRITE) ? sh_next[SH_W-1] : 1'b0;
    valid_d     = (state_d == WRITE);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      control_q   <= 1'b0;
      wd_q        <= 1'b0;
      valid_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      control_q   <= control_d;
      wd_q        <= wd_d;
      valid_q     <= valid_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign control   = control_q;
  assign wD        = wd_q;
  assign valid     = valid_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
